// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write FIFO; queued bytes go out back-to-back.
// One bit lasts DIV_CNT+1 clocks. The line is driven from a register and idles high.
`timescale 1ns/1ps
module uart_tx #(
  parameter int                 DIV_WID = 9,
  parameter logic [DIV_WID-1:0] DIV_CNT = 9'd433,
  parameter int                 FIFO_AW = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_dataen,
  output logic       o_full,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_uart_miso
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [DIV_WID-1:0]   div, div_n;
  logic [2:0]           bitcnt, bitcnt_n;
  logic [7:0]           shift, shift_n;
  logic                 line_n;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_n;
  logic                 empty, wr_en, pop;

  assign o_full = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign wr_en  = i_dataen & ~o_full;

  always_comb begin
    state_n  = state;
    div_n    = ((state != IDLE) && (div != '0)) ? div - DIV_WID'(1) : div;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    line_n   = o_uart_miso;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        line_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          div_n   = DIV_CNT;
          line_n  = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (div == '0) begin
          div_n    = DIV_CNT;
          line_n   = shift[0];
          bitcnt_n = 3'd0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (div == '0) begin
          div_n = DIV_CNT;
          if (bitcnt != 3'd7) begin
            shift_n  = {1'b0, shift[7:1]};
            line_n   = shift[1];
            bitcnt_n = bitcnt + 3'd1;
          end else begin
            line_n  = 1'b1;
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (div == '0) begin
          // Chain straight into the next start bit so frames stay contiguous.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            div_n   = DIV_CNT;
            line_n  = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    count_n = count;
    case ({wr_en, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      div         <= '0;
      bitcnt      <= '0;
      shift       <= '0;
      o_uart_miso <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      bitcnt      <= bitcnt_n;
      shift       <= shift_n;
      o_uart_miso <= line_n;
      count       <= count_n;
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
      o_busy      <= (state_n != IDLE) | (count_n != '0);
      o_overflow  <= i_dataen & o_full;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

endmodule
